uart_word_sender: RTL and testbench

//  Transmit side of the UART word link. On a start pulse, sends a fixed
//  MSG_LEN-byte ASCII message (default "HELLO") as back-to-back 8N1 frames on TxD.

---
 rtl/uart_word_sender_pkg.sv | 31 +++
 rtl/uart_word_sender_if.sv | 12 +
 rtl/uart_word_sender_tx_byte.sv | 61 ++++++
 rtl/uart_word_sender.sv | 128 ++++++++++++
 tb/tb_uart_word_sender.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_word_sender_pkg.sv
// Shared types, constants and helpers for the UART word sender and its
// receive-side word detector.
package uart_word_sender_pkg;

  // Message FSM states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    GAP  = 3'd3,
    FIN  = 3'd4
  } state_t;

  // 7-segment patterns (active low) shared with the detector's HEX path
  localparam logic [7:0] SEG_H = 8'b10001001;
  localparam logic [7:0] SEG_E = 8'b10000110;
  localparam logic [7:0] SEG_L = 8'b11000111;
  localparam logic [7:0] SEG_O = 8'b10100011;

  // ASCII codes of the default message characters
  localparam logic [7:0] ASCII_H = 8'h48;
  localparam logic [7:0] ASCII_E = 8'h45;
  localparam logic [7:0] ASCII_L = 8'h4C;
  localparam logic [7:0] ASCII_O = 8'h4F;

  // Clocks per bit; integer division, so the line rate rounds slightly fast
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_word_sender_if.sv
// Handshake and status bundle between a message requester and the word sender.
interface uart_word_sender_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       TxD;
  logic [7:0] tx_byte;
  logic [3:0] byte_idx;

  modport master (output start, input busy, done, TxD, tx_byte, byte_idx);
  modport slave  (input start, output busy, done, TxD, tx_byte, byte_idx);
endinterface

// File: rtl/uart_word_sender_tx_byte.sv
// Single 8N1 frame serializer: start bit, eight data bits LSB first, stop bit.
// Every bit lasts exactly DIV clocks because the baud counter restarts on
// each byte_go rather than free-running.
module uart_tx_byte
  import uart_word_sender_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_go,
  input  logic [7:0] din,
  output logic       TxD,
  output logic       frame_done,
  output logic       tx_active
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;

  // Last clock of the stop bit; the message FSM advances on this edge
  assign frame_done = tx_active && (bit_cnt == 4'd9) && (baud_cnt == BAUD_LAST);

  // Load the frame, then shift one bit out every DIV clocks; line held at mark otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      TxD       <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '1;
      tx_active <= 1'b0;
    end else if (byte_go) begin
      TxD       <= 1'b0;
      shreg     <= {1'b1, din};
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      tx_active <= 1'b1;
    end else if (tx_active) begin
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          tx_active <= 1'b0;
          TxD       <= 1'b1;
        end else begin
          TxD     <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_word_sender.sv
// Sends a fixed MSG_LEN-byte message as back-to-back 8N1 frames on one start
// pulse, with optional mark gaps between frames, plus busy/done and the
// current byte/index for the HEX display.
module uart_word_sender
  import uart_word_sender_pkg::*;
#(
  parameter int                   CLK_FREQ = 50_000_000,
  parameter int                   BAUD     = 115_200,
  parameter int                   MSG_LEN  = 5,
  parameter logic [8*MSG_LEN-1:0] MSG      = "HELLO",
  parameter int                   GAP_BITS = 0
) (
  input logic              clk,
  input logic              rst,
  uart_word_sender_if.slave bus
);

  localparam int DIV     = baud_div(CLK_FREQ, BAUD);
  localparam int GAP_CYC = (GAP_BITS > 0) ? GAP_BITS * DIV : 1;
  localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [3:0]    LAST_IDX = 4'(MSG_LEN - 1);

  state_t        state;
  logic          armed;
  logic          byte_go;
  logic          busy_q;
  logic          done_q;
  logic [7:0]    tx_byte_q;
  logic [3:0]    byte_idx_q;
  logic [GW-1:0] gap_cnt;
  logic          frame_done;
  logic          tx_active;
  logic          txd_line;

  // First message byte sits in the top bits of the packed string
  function automatic logic [7:0] msg_byte(input logic [3:0] idx);
    return MSG[8*(MSG_LEN - 1 - int'(idx)) +: 8];
  endfunction

  uart_tx_byte #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .byte_go   (byte_go),
    .din       (tx_byte_q),
    .TxD       (txd_line),
    .frame_done(frame_done),
    .tx_active (tx_active)
  );

  assign bus.TxD      = txd_line;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tx_byte  = tx_byte_q;
  assign bus.byte_idx = byte_idx_q;

  // Message sequencer; byte_go and tx_byte are set on entry to LOAD so the
  // shifter latches the new byte on the clock that leaves LOAD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      armed      <= 1'b0;
      byte_go    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_byte_q  <= '0;
      byte_idx_q <= '0;
      gap_cnt    <= '0;
    end else begin
      armed   <= 1'b1;
      byte_go <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && armed && !tx_active) begin
            state      <= LOAD;
            byte_idx_q <= 4'd0;
            tx_byte_q  <= msg_byte(4'd0);
            byte_go    <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          state <= SEND;
        end
        SEND: begin
          if (frame_done) begin
            if (byte_idx_q == LAST_IDX) begin
              state  <= FIN;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else if (GAP_BITS > 0) begin
              state   <= GAP;
              gap_cnt <= '0;
            end else begin
              state      <= LOAD;
              byte_idx_q <= byte_idx_q + 4'd1;
              tx_byte_q  <= msg_byte(byte_idx_q + 4'd1);
              byte_go    <= 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state      <= LOAD;
            byte_idx_q <= byte_idx_q + 4'd1;
            tx_byte_q  <= msg_byte(byte_idx_q + 4'd1);
            byte_go    <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        FIN: begin
          state      <= IDLE;
          tx_byte_q  <= '0;
          byte_idx_q <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_sender.sv
// Bench for uart_word_sender at CLK_FREQ=16, BAUD=1 (16 clocks per bit).
// "Clock n" after a start means the cycle ending at the n-th rising edge
// following the edge that accepted start; lines are sampled on falling edges.
module tb_uart_word_sender;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   frame_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_word_sender_if w0 ();
  uart_word_sender_if w1 ();
  uart_word_sender_if w2 ();

  uart_word_sender #(.CLK_FREQ(16), .BAUD(1), .MSG_LEN(5), .MSG("HELLO"), .GAP_BITS(0))
    dut (.clk(clk), .rst(rst), .bus(w0.slave));
  uart_word_sender #(.CLK_FREQ(16), .BAUD(1), .MSG_LEN(1), .MSG("A"), .GAP_BITS(2))
    dut_g1 (.clk(clk), .rst(rst), .bus(w1.slave));
  uart_word_sender #(.CLK_FREQ(16), .BAUD(1), .MSG_LEN(2), .MSG("AB"), .GAP_BITS(2))
    dut_g2 (.clk(clk), .rst(rst), .bus(w2.slave));

  // Scoreboard: expected bytes queued at start, received bytes queued by the monitor
  logic [7:0] exp0[$], exp1[$], exp2[$];
  logic [7:0] rx0[$], rx1[$], rx2[$];

  logic       in_fr[3] = '{1'b0, 1'b0, 1'b0};
  int         ph[3];
  logic [7:0] sh[3];

  // Independent 8N1 decoder per line, sampling each bit at its centre
  always @(negedge clk) begin
    logic line_v[3];
    line_v[0] = w0.TxD;
    line_v[1] = w1.TxD;
    line_v[2] = w2.TxD;
    for (int l = 0; l < 3; l++) begin
      if (!rst) begin
        in_fr[l] = 1'b0;
      end else if (!in_fr[l]) begin
        if (line_v[l] === 1'b0) begin
          in_fr[l] = 1'b1;
          ph[l] = 0;
        end
      end else begin
        ph[l]++;
        if (ph[l] == 7) begin
          if (line_v[l] !== 1'b0) frame_err++;
        end else if (ph[l] > 7 && ph[l] < 151 && ((ph[l] - 7) % 16) == 0) begin
          sh[l] = {line_v[l], sh[l][7:1]};
        end else if (ph[l] == 151) begin
          if (line_v[l] !== 1'b1) frame_err++;
          case (l)
            0: rx0.push_back(sh[l]);
            1: rx1.push_back(sh[l]);
            default: rx2.push_back(sh[l]);
          endcase
          in_fr[l] = 1'b0;
        end
      end
    end
  end

  task automatic set_start(input int l, input logic v);
    case (l)
      0: w0.start = v;
      1: w1.start = v;
      default: w2.start = v;
    endcase
  endtask

  // Returns right after the accepting rising edge; next falling edge is clock 1
  task automatic pulse_start(input int l);
    @(negedge clk);
    set_start(l, 1'b1);
    @(posedge clk);
    #1 set_start(l, 1'b0);
  endtask

  task automatic push_hello();
    exp0.push_back(8'h48); exp0.push_back(8'h45); exp0.push_back(8'h4C);
    exp0.push_back(8'h4C); exp0.push_back(8'h4F);
  endtask

  task automatic compare_line0(input string tag);
    logic [7:0] e, g;
    while (exp0.size() > 0) begin
      e = exp0.pop_front();
      n_cmp++;
      if (rx0.size() == 0) begin
        n_err++; $display("[TB] FAIL %s_byte: got none, want %h", tag, e);
      end else begin
        g = rx0.pop_front();
        if (g !== e) begin n_err++; $display("[TB] FAIL %s_byte: got %h, want %h", tag, g, e); end
      end
    end
    n_cmp++;
    if (rx0.size() != 0) begin n_err++; $display("[TB] FAIL %s_extra: got %0d extra frames, want 0", tag, rx0.size()); end
    rx0.delete();
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b0;
    set_start(0, 1'b0); set_start(1, 1'b0); set_start(2, 1'b0);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (w0.TxD !== 1'b1 || w0.busy !== 1'b0 || w0.done !== 1'b0 || w0.tx_byte !== 8'h00) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("[TB] FAIL reset_hold: got %0d bad cycles, want 0", bad); end
    n_cmp++; if (w0.TxD !== 1'b1) begin n_err++; $display("[TB] FAIL reset_txd: got %b, want 1", w0.TxD); end
    n_cmp++; if (w0.busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b, want 0", w0.busy); end
    n_cmp++; if (w0.byte_idx !== 4'd0) begin n_err++; $display("[TB] FAIL reset_idx: got %0d, want 0", w0.byte_idx); end
    // start asserted together with reset release must be ignored
    rst = 1'b1;
    set_start(0, 1'b1);
    @(posedge clk);
    #1 set_start(0, 1'b0);
    bad = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (w0.busy !== 1'b0 || w0.TxD !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("[TB] FAIL release_start: got %0d active cycles, want 0", bad); end
  endtask

  task automatic test_message();
    int first_low = 0, done_cnt = 0, done_at = 0, busy_bad = 0;
    push_hello();
    pulse_start(0);
    for (int c = 1; c <= 830; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++; if (w0.TxD !== 1'b1) begin n_err++; $display("[TB] FAIL latency_c1: got TxD %b, want 1", w0.TxD); end
      end
      if (first_low == 0 && w0.TxD === 1'b0) first_low = c;
      if (c == 17) begin
        n_cmp++; if (w0.TxD !== 1'b0) begin n_err++; $display("[TB] FAIL startbit_end: got TxD %b, want 0", w0.TxD); end
      end
      if (c == 10) begin
        n_cmp++; if (w0.tx_byte !== 8'h48) begin n_err++; $display("[TB] FAIL tx_byte0: got %h, want 48", w0.tx_byte); end
        n_cmp++; if (w0.byte_idx !== 4'd0) begin n_err++; $display("[TB] FAIL byte_idx0: got %0d, want 0", w0.byte_idx); end
      end
      if (c == 170) begin
        n_cmp++; if (w0.tx_byte !== 8'h45) begin n_err++; $display("[TB] FAIL tx_byte1: got %h, want 45", w0.tx_byte); end
        n_cmp++; if (w0.byte_idx !== 4'd1) begin n_err++; $display("[TB] FAIL byte_idx1: got %0d, want 1", w0.byte_idx); end
      end
      if (c <= 805 && w0.busy !== 1'b1) busy_bad++;
      if (c == 806) begin
        n_cmp++; if (w0.busy !== 1'b0) begin n_err++; $display("[TB] FAIL busy_end: got %b, want 0", w0.busy); end
      end
      if (w0.done === 1'b1) begin done_cnt++; done_at = c; end
    end
    n_cmp++; if (first_low != 2) begin n_err++; $display("[TB] FAIL latency: got clock %0d, want 2", first_low); end
    n_cmp++; if (busy_bad != 0) begin n_err++; $display("[TB] FAIL busy_span: got %0d low cycles, want 0", busy_bad); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("[TB] FAIL done_count: got %0d, want 1", done_cnt); end
    n_cmp++; if (done_at != 806) begin n_err++; $display("[TB] FAIL done_time: got clock %0d, want 806", done_at); end
    n_cmp++; if (w0.tx_byte !== 8'h00) begin n_err++; $display("[TB] FAIL idle_byte: got %h, want 00", w0.tx_byte); end
    compare_line0("msg");
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0, done_at = 0;
    push_hello();
    pulse_start(0);
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (c == 40 || c == 500) set_start(0, 1'b1);
      if (c == 41 || c == 501) set_start(0, 1'b0);
      if (w0.done === 1'b1) begin done_cnt++; done_at = c; end
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("[TB] FAIL ignore_done_count: got %0d, want 1", done_cnt); end
    n_cmp++; if (done_at != 806) begin n_err++; $display("[TB] FAIL ignore_done_time: got clock %0d, want 806", done_at); end
    n_cmp++; if (w0.busy !== 1'b0) begin n_err++; $display("[TB] FAIL ignore_busy: got %b, want 0", w0.busy); end
    compare_line0("ignore");
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    push_hello();
    pulse_start(0);
    repeat (300) @(negedge clk);
    n_cmp++; if (w0.TxD !== 1'b0) begin n_err++; $display("[TB] FAIL mid_before: got TxD %b, want 0", w0.TxD); end
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (w0.TxD !== 1'b1) begin n_err++; $display("[TB] FAIL mid_txd: got %b, want 1", w0.TxD); end
    n_cmp++; if (w0.busy !== 1'b0) begin n_err++; $display("[TB] FAIL mid_busy: got %b, want 0", w0.busy); end
    n_cmp++;
    if (rx0.size() != 1 || rx0[0] !== 8'h48) begin
      n_err++; $display("[TB] FAIL mid_partial: got %0d frames, want 1 frame of 48", rx0.size());
    end
    exp0.delete();
    rx0.delete();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    push_hello();
    pulse_start(0);
    for (int c = 1; c <= 830; c++) begin
      @(negedge clk);
      if (w0.done === 1'b1) done_cnt++;
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("[TB] FAIL mid_done: got %0d, want 1", done_cnt); end
    compare_line0("after_reset");
  endtask

  task automatic test_gap();
    int done_at = 0, first_low1 = 0, gap_bad = 0;
    logic [7:0] e, g;
    exp1.push_back(8'h41);
    pulse_start(1);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (w1.done === 1'b1) done_at = c;
    end
    n_cmp++; if (done_at != 162) begin n_err++; $display("[TB] FAIL single_done: got clock %0d, want 162", done_at); end
    while (exp1.size() > 0) begin
      e = exp1.pop_front();
      n_cmp++;
      if (rx1.size() == 0) begin n_err++; $display("[TB] FAIL single_byte: got none, want %h", e); end
      else begin
        g = rx1.pop_front();
        if (g !== e) begin n_err++; $display("[TB] FAIL single_byte: got %h, want %h", g, e); end
      end
    end
    n_cmp++; if (rx1.size() != 0) begin n_err++; $display("[TB] FAIL single_extra: got %0d, want 0", rx1.size()); end

    exp2.push_back(8'h41); exp2.push_back(8'h42);
    done_at = 0;
    pulse_start(2);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c >= 146 && c <= 194 && w2.TxD !== 1'b1) gap_bad++;
      if (c > 170 && first_low1 == 0 && w2.TxD === 1'b0) first_low1 = c;
      if (w2.done === 1'b1) done_at = c;
    end
    n_cmp++; if (gap_bad != 0) begin n_err++; $display("[TB] FAIL gap_mark: got %0d low cycles, want 0", gap_bad); end
    n_cmp++; if (first_low1 != 195) begin n_err++; $display("[TB] FAIL gap_next: got clock %0d, want 195", first_low1); end
    n_cmp++; if (done_at != 355) begin n_err++; $display("[TB] FAIL gap_done: got clock %0d, want 355", done_at); end
    while (exp2.size() > 0) begin
      e = exp2.pop_front();
      n_cmp++;
      if (rx2.size() == 0) begin n_err++; $display("[TB] FAIL gap_byte: got none, want %h", e); end
      else begin
        g = rx2.pop_front();
        if (g !== e) begin n_err++; $display("[TB] FAIL gap_byte: got %h, want %h", g, e); end
      end
    end
    n_cmp++; if (rx2.size() != 0) begin n_err++; $display("[TB] FAIL gap_extra: got %0d, want 0", rx2.size()); end
  endtask

  initial begin
    w0.start = 1'b0;
    w1.start = 1'b0;
    w2.start = 1'b0;
    $display("[TB] uart_word_sender bench starting");
    test_reset();
    test_message();
    test_back_to_back();
    test_reset_mid();
    test_gap();
    n_cmp++;
    if (frame_err != 0) begin n_err++; $display("[TB] FAIL framing: got %0d bad start/stop bits, want 0", frame_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
